// File: rtl/ped_walk_ctrl.sv
// Pedestrian WALK / flashing DON'T WALK controller slaved to traffic_light's leds bus.
// Optional audible WALK chirp output is built when PED_AUDIO_EN is defined.
module ped_walk_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WALK_CYCLES     = 3,
    parameter int FLASH_HALF      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] leds,
    input  logic       ped_btn,
    output logic       walk,
    output logic       dont_walk,
    output logic       req_pending,
    output logic       fault
`ifdef PED_AUDIO_EN
    ,
    output logic       chirp
`endif
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int WW = $clog2(WALK_CYCLES + 1);
    localparam int FW = $clog2(FLASH_HALF + 1);

    localparam logic [DW-1:0] DEB_MAX    = DW'(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WW-1:0] WALK_LOAD  = WW'(WALK_CYCLES - 1);
    localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_HALF - 1);

    localparam logic [2:0] LEDS_OFF = 3'b000;
    localparam logic [2:0] LEDS_RED = 3'b001;
    localparam logic [2:0] LEDS_YEL = 3'b010;
    localparam logic [2:0] LEDS_GRN = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WALK  = 2'd1,
        FLASH = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    sync_q;
    logic [DW-1:0] deb_cnt, deb_nxt;
    logic [2:0]    prev_leds;
    logic [WW-1:0] walk_cnt, walk_cnt_nxt;
    logic [FW-1:0] flash_cnt, flash_cnt_nxt;
    logic          walk_nxt, dw_nxt, req_nxt, fault_nxt;
    logic          illegal, is_red, red_onset, press_done, serve;

    // Anything other than one-hot or all-off (including X/Z) is illegal.
    always_comb begin
        illegal = 1'b1;
        case (leds)
            LEDS_OFF, LEDS_RED, LEDS_YEL, LEDS_GRN: illegal = 1'b0;
            default:                                illegal = 1'b1;
        endcase
    end

    assign is_red     = (leds == LEDS_RED);
    assign red_onset  = is_red && (prev_leds != LEDS_RED);
    assign press_done = sync_q[1] && (deb_cnt == DEB_LAST);

    always_comb begin
        deb_nxt = deb_cnt;
        if (!sync_q[1])
            deb_nxt = '0;
        else if (deb_cnt != DEB_MAX)
            deb_nxt = deb_cnt + DW'(1);
    end

    always_comb begin
        state_nxt     = state;
        walk_cnt_nxt  = walk_cnt;
        flash_cnt_nxt = flash_cnt;
        walk_nxt      = 1'b0;
        dw_nxt        = 1'b1;
        fault_nxt     = 1'b0;
        serve         = 1'b0;

        if (illegal) begin
            state_nxt = FAULT;
            fault_nxt = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (red_onset && req_pending) begin
                        state_nxt    = WALK;
                        walk_cnt_nxt = WALK_LOAD;
                        walk_nxt     = 1'b1;
                        dw_nxt       = 1'b0;
                        serve        = 1'b1;
                    end
                end
                WALK: begin
                    if (!is_red) begin
                        state_nxt = IDLE;
                    end else if (walk_cnt == '0) begin
                        state_nxt     = FLASH;
                        flash_cnt_nxt = FLASH_LOAD;
                    end else begin
                        walk_cnt_nxt = walk_cnt - WW'(1);
                        walk_nxt     = 1'b1;
                        dw_nxt       = 1'b0;
                    end
                end
                FLASH: begin
                    if (!is_red) begin
                        state_nxt = IDLE;
                    end else if (flash_cnt == '0) begin
                        dw_nxt        = ~dont_walk;
                        flash_cnt_nxt = FLASH_LOAD;
                    end else begin
                        dw_nxt        = dont_walk;
                        flash_cnt_nxt = flash_cnt - FW'(1);
                    end
                end
                FAULT: begin
                    if (leds == LEDS_OFF)
                        state_nxt = IDLE;
                    else
                        fault_nxt = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A press completing on the serving edge re-arms the request for the next red.
    always_comb begin
        req_nxt = req_pending;
        if (press_done)
            req_nxt = 1'b1;
        else if (serve)
            req_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sync_q      <= '0;
            deb_cnt     <= '0;
            prev_leds   <= LEDS_OFF;
            walk_cnt    <= '0;
            flash_cnt   <= '0;
            walk        <= 1'b0;
            dont_walk   <= 1'b1;
            req_pending <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_nxt;
            sync_q      <= {sync_q[0], ped_btn};
            deb_cnt     <= deb_nxt;
            prev_leds   <= leds;
            walk_cnt    <= walk_cnt_nxt;
            flash_cnt   <= flash_cnt_nxt;
            walk        <= walk_nxt;
            dont_walk   <= dw_nxt;
            req_pending <= req_nxt;
            fault       <= fault_nxt;
        end
    end

`ifdef PED_AUDIO_EN
    logic chirp_nxt;

    always_comb begin
        chirp_nxt = 1'b0;
        if (state_nxt == WALK)
            chirp_nxt = (state == WALK) ? ~chirp : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            chirp <= 1'b0;
        else
            chirp <= chirp_nxt;
    end
`endif

endmodule

// File: tb/tb_ped_walk_ctrl.sv
// Directed bench for ped_walk_ctrl with default parameters (debounce 4, walk 3, flash half 1).
module tb_ped_walk_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] leds;
    logic       ped_btn;
    logic       walk, dont_walk, req_pending, fault;
`ifdef PED_AUDIO_EN
    logic       chirp;
`endif

    int tests = 0;
    int fails = 0;

    ped_walk_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .WALK_CYCLES    (3),
        .FLASH_HALF     (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .leds       (leds),
        .ped_btn    (ped_btn),
        .walk       (walk),
        .dont_walk  (dont_walk),
        .req_pending(req_pending),
        .fault      (fault)
`ifdef PED_AUDIO_EN
        ,
        .chirp      (chirp)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic w, input logic dw,
                           input logic rq, input logic f);
        chk({tag, ".walk"}, walk, w);
        chk({tag, ".dont_walk"}, dont_walk, dw);
        chk({tag, ".req"}, req_pending, rq);
        chk({tag, ".fault"}, fault, f);
    endtask

    task automatic chk_chirp(input string tag, input logic exp);
`ifdef PED_AUDIO_EN
        chk(tag, chirp, exp);
`endif
    endtask

    // Hold the button for n posedges then release.
    task automatic press(input int n);
        ped_btn = 1'b1;
        tick(n);
        ped_btn = 1'b0;
    endtask

    initial begin
        rst = 1'b1; leds = 3'b000; ped_btn = 1'b0;
        tick(2);
        rst = 1'b0;
        tick();
        chk_all("reset", 1'b0, 1'b1, 1'b0, 1'b0);
        chk_chirp("reset.chirp", 1'b0);

        // Short press is rejected; 6-posedge press latches on the 6th.
        press(3);
        tick(5);
        chk("short_press", req_pending, 1'b0);
        ped_btn = 1'b1;
        tick(5);
        chk("press_5th", req_pending, 1'b0);
        tick();
        chk("press_6th", req_pending, 1'b1);
        ped_btn = 1'b0;

        // Full WALK / FLASH cycle.
        leds = 3'b100; tick();
        leds = 3'b010; tick();
        chk_all("yellow", 1'b0, 1'b1, 1'b1, 1'b0);
        leds = 3'b001; tick();
        chk_all("walk0", 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("walk1", 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("walk2", 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("flash0", 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("flash1", 1'b0, 1'b0, 1'b0, 1'b0);
        leds = 3'b100; tick();
        chk_all("flash_end", 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); chk("idle_solid", dont_walk, 1'b1);

        // Press completing on the red-onset edge waits for the next red.
        ped_btn = 1'b1;
        tick(5);
        leds = 3'b001; tick();
        chk_all("same_edge", 1'b0, 1'b1, 1'b1, 1'b0);
        ped_btn = 1'b0;
        leds = 3'b100; tick();
        leds = 3'b001; tick();
        chk_all("next_red", 1'b1, 1'b0, 1'b0, 1'b0);

        // Abort from WALK when red ends early.
        leds = 3'b100; tick();
        chk_all("abort_a", 1'b0, 1'b1, 1'b0, 1'b0);
        press(6);
        chk("abort_req", req_pending, 1'b1);
        leds = 3'b001; tick();
        chk("abort_walk", walk, 1'b1);
        leds = 3'b100; tick();
        chk_all("abort_b", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("abort_idle", walk, 1'b0);

        // Press completing during FLASH is held for the following red.
        press(6);
        leds = 3'b001; tick();
        chk("fw_walk0", walk, 1'b1);
        ped_btn = 1'b1;
        tick(3);
        chk_all("fw_flash0", 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("fw_flash1", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("fw_flash2", 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("fw_flash3", 1'b0, 1'b0, 1'b1, 1'b0);
        ped_btn = 1'b0;
        leds = 3'b100; tick();
        chk_all("fw_idle", 1'b0, 1'b1, 1'b1, 1'b0);
        leds = 3'b001; tick();
        chk_all("fw_served", 1'b1, 1'b0, 1'b0, 1'b0);
        leds = 3'b100; tick();

        // Illegal lamp codes; request survives the fault.
        leds = 3'b000; tick();
        press(6);
        leds = 3'b110; tick();
        chk_all("fault_in", 1'b0, 1'b1, 1'b1, 1'b1);
        leds = 3'b001; tick();
        chk_all("fault_red", 1'b0, 1'b1, 1'b1, 1'b1);
        leds = 3'b000; tick();
        chk_all("fault_out", 1'b0, 1'b1, 1'b1, 1'b0);
        leds = 3'b111; tick();
        chk("fault_111", fault, 1'b1);
        leds = 3'b000; tick();
        chk("fault_clr", fault, 1'b0);

        // Preserved request is served at the next red; chirp pattern in WALK.
        leds = 3'b001; tick();
        chk_all("post_fault", 1'b1, 1'b0, 1'b0, 1'b0);
        chk_chirp("chirp0", 1'b1);
        tick(); chk_chirp("chirp1", 1'b0);
        chk("post_walk1", walk, 1'b1);
        tick(); chk_chirp("chirp2", 1'b1);
        tick(); chk_chirp("chirp3", 1'b0);
        chk("post_flash", walk, 1'b0);
        leds = 3'b100; tick();

        // Reset dominates mid-WALK.
        press(6);
        leds = 3'b001; tick();
        chk("pre_rst_walk", walk, 1'b1);
        rst = 1'b1; tick();
        chk_all("mid_rst", 1'b0, 1'b1, 1'b0, 1'b0);
        chk_chirp("mid_rst.chirp", 1'b0);
        rst = 1'b0; tick();
        chk_all("after_rst", 1'b0, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
